fib_arbiter: RTL and testbench
==============================

// Module: fib_arbiter
// PURPOSE
//  Shares one fib core (go/n/result/overflow/done) among NUM_REQ requesters.
//  Grants are round-robin. The arbiter issues one go pulse per accepted request, waits for the core's done,
//  then returns result/overflow on a shared response bus tagged with the requester id.
//  A watchdog abandons a core run that never completes.
// PARAMETERS
//  NUM_REQ       4    number of requesters (>=2)
//  INPUT_WIDTH   6    width of n
//  OUTPUT_WIDTH  32   width of result
//  TIMEOUT       4095 max cycles in WAIT before abort (>=2); counter is $clog2(TIMEOUT+1) bits
// PORTS
//  clk           in   1                      clock, all logic on rising edge
//  rst           in   1                      asynchronous reset, active-low (0 = reset)
//  req_valid     in   NUM_REQ                per-requester request; held until its req_ready
//  req_n         in   NUM_REQ*INPUT_WIDTH    per-requester n, packed [i*INPUT_WIDTH +: INPUT_WIDTH]
//  req_ready     out  NUM_REQ                one-hot, 1-cycle accept pulse
//  resp_valid    out  1                      1-cycle response pulse
//  resp_id       out  $clog2(NUM_REQ)        requester the response belongs to
//  resp_result   out  OUTPUT_WIDTH           core result
//  resp_overflow out  1                      core overflow
//  resp_timeout  out  1                      1 = run aborted; result/overflow are 0
//  busy          out  1                      1 whenever state != IDLE
//  core_go       out  1                      to fib go
//  core_n        out  INPUT_WIDTH            to fib n
//  core_result   in   OUTPUT_WIDTH           from fib result
//  core_overflow in   1                      from fib overflow
//  core_done     in   1                      from fib done
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr pointer=0.
//   All outputs are 0: req_ready, resp_*, busy, core_go, core_n.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid, pick the first set bit at or after ptr, scanning upward with wrap.
//   In that cycle (registered, visible next cycle):
//    - assert req_ready[g]
//    - latch g and req_n[g]
//    - drive core_n
//    - go to ISSUE.
//  ISSUE: core_go=1 for exactly this cycle; core_n is held stable from ISSUE through RESP; go to WAIT.
//  WAIT: core_go=0. The core contract (go&&done |=> !done) guarantees core_done=0 in the first WAIT cycle.
//   - core_done=1 -> latch core_result/core_overflow, go to RESP.
//   - watchdog counts WAIT cycles; on reaching TIMEOUT -> RESP with resp_timeout=1.
//  RESP: resp_valid=1 for one cycle with resp_id=g; ptr <= g+1 (mod NUM_REQ); go to IDLE.
//  Latency: accept -> resp_valid = 3 + core latency cycles.
//   Back-to-back: the next req_ready comes no earlier than 1 cycle after resp_valid.
//  core_done already high in IDLE from a previous run is ignored; only WAIT samples it.
//  req_valid dropped before req_ready: legal, the request is simply not granted.
//   req_valid changes while not IDLE: ignored.
//  Simultaneous requests: exactly one grant per transaction. With all requesters asserting, the grant order is
//   ptr, ptr+1, ... (mod NUM_REQ), which gives no starvation.
//  Reset mid-operation: immediate return to IDLE and core_go=0; any pending response is lost.
//   The core is reset by the same system reset.
//  Arithmetic: ptr wraps at NUM_REQ (not necessarily a power of two).
//   The watchdog saturates; it does not wrap.
// STRUCTURE
//  fib_arb_pkg holds: state_t enum {IDLE,ISSUE,WAIT,RESP}; function rr_pick(req,ptr) returning {found,idx}.
//  Sub-module rr_arbiter (NUM_REQ): combinational pick plus registered pointer, reusable elsewhere.
//  Top: FSM, latches, watchdog.
// TESTING
//  1 Single req0, n=10 -> one req_ready[0] pulse, core_go one cycle, resp_valid id=0 result=55 overflow=0.
//  2 All 4 req held, n=5,6,7,8 -> responses id 0,1,2,3 in order, results 5,8,13,21, then id 0 again.
//  3 ptr=2 with req1 and req3 -> grant 3 first, then 1 (wrap).
//  4 n=63, OUTPUT_WIDTH=32 -> resp_overflow=1; core_done stale-high before the next grant is not taken as done.
//  5 Stub core never raises done, TIMEOUT=20 -> resp_timeout=1, result 0, at 20 WAIT cycles; next req served.
//  6 rst=0 during WAIT -> all outputs 0 asynchronously, no resp_valid; normal service after release.
//  Bench assertions: core_go never high 2 consecutive cycles; $onehot0(req_ready); resp_valid is one cycle wide.

Source files
------------

// File: rtl/fib_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_arb_pkg
// Description : Shared types and round-robin pick helper for fib_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int c_max_req = 32;
  localparam int c_idx_w   = 5;

  typedef struct packed {
    logic               found;
    logic [c_idx_w-1:0] idx;
  } pick_t;

  // Request vector is zero-padded to c_max_req, so wrapping at c_max_req
  // yields the same order as wrapping at the real requester count.
  function automatic pick_t rr_pick(input logic [c_max_req-1:0] req,
                                    input logic [c_idx_w-1:0]   ptr);
    pick_t              r;
    logic [c_idx_w-1:0] idx;
    r = '0;
    for (int i = 0; i < c_max_req; i++) begin
      idx = ptr + c_idx_w'(i);
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick with a registered pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fib_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_advance,
  input  logic [$clog2(NUM_REQ)-1:0] i_last_id,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int c_idw = $clog2(NUM_REQ);

  logic [c_idw-1:0] r_ptr;
  pick_t            w_pick;

  assign w_pick  = rr_pick(c_max_req'(i_req), c_idx_w'(r_ptr));
  assign o_found = w_pick.found;
  assign o_idx   = c_idw'(w_pick.idx);

  // Pointer moves to the requester after the one just served, wrapping at NUM_REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      if (i_last_id == c_idw'(NUM_REQ - 1)) r_ptr <= '0;
      else                                   r_ptr <= i_last_id + c_idw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fib_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fib_arbiter
// Description : Round-robin sharing of one fib core among NUM_REQ requesters,
//               with a watchdog that abandons runs that never complete.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_arbiter
  import fib_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32,
  parameter int TIMEOUT      = 4095
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]     resp_id,
  output logic [OUTPUT_WIDTH-1:0]        resp_result,
  output logic                           resp_overflow,
  output logic                           resp_timeout,
  output logic                           busy,
  output logic                           core_go,
  output logic [INPUT_WIDTH-1:0]         core_n,
  input  logic [OUTPUT_WIDTH-1:0]        core_result,
  input  logic                           core_overflow,
  input  logic                           core_done
);

  localparam int               c_idw       = $clog2(NUM_REQ);
  localparam int               c_wdw       = $clog2(TIMEOUT + 1);
  localparam logic [c_wdw-1:0] c_wdog_last = c_wdw'(TIMEOUT - 1);

  state_t                  r_state;
  logic [NUM_REQ-1:0]      r_req_ready;
  logic                    r_resp_valid;
  logic [c_idw-1:0]        r_resp_id;
  logic [OUTPUT_WIDTH-1:0] r_resp_result;
  logic                    r_resp_overflow;
  logic                    r_resp_timeout;
  logic                    r_busy;
  logic                    r_core_go;
  logic [INPUT_WIDTH-1:0]  r_core_n;
  logic [c_idw-1:0]        r_gnt;
  logic [c_wdw-1:0]        r_wdog;

  logic                    w_found;
  logic [c_idw-1:0]        w_idx;
  logic                    w_advance;
  logic [INPUT_WIDTH-1:0]  w_req_n [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_n[gi] = req_n[gi*INPUT_WIDTH +: INPUT_WIDTH];
  end

  assign w_advance = (r_state == RESP);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_advance (w_advance),
    .i_last_id (r_gnt),
    .o_found   (w_found),
    .o_idx     (w_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_req_ready     <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_id       <= '0;
      r_resp_result   <= '0;
      r_resp_overflow <= 1'b0;
      r_resp_timeout  <= 1'b0;
      r_busy          <= 1'b0;
      r_core_go       <= 1'b0;
      r_core_n        <= '0;
      r_gnt           <= '0;
      r_wdog          <= '0;
    end else begin
      r_req_ready  <= '0;
      r_core_go    <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_req_ready <= NUM_REQ'(1) << w_idx;
            r_gnt       <= w_idx;
            r_core_n    <= w_req_n[w_idx];
            r_core_go   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_wdog  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            r_resp_valid    <= 1'b1;
            r_resp_id       <= r_gnt;
            r_resp_result   <= core_result;
            r_resp_overflow <= core_overflow;
            r_resp_timeout  <= 1'b0;
            r_state         <= RESP;
          end else if (r_wdog == c_wdog_last) begin
            // TIMEOUT-th WAIT cycle without done: abandon the run
            r_resp_valid    <= 1'b1;
            r_resp_id       <= r_gnt;
            r_resp_result   <= '0;
            r_resp_overflow <= 1'b0;
            r_resp_timeout  <= 1'b1;
            r_state         <= RESP;
          end else begin
            r_wdog <= r_wdog + c_wdw'(1);
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_result   = r_resp_result;
  assign resp_overflow = r_resp_overflow;
  assign resp_timeout  = r_resp_timeout;
  assign busy          = r_busy;
  assign core_go       = r_core_go;
  assign core_n        = r_core_n;

endmodule
`default_nettype wire

// File: tb/tb_fib_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_arbiter
// Description : Self-checking bench for fib_arbiter with a fib core stub.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fib_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IW      = 6;
  localparam int OW      = 32;
  localparam int TIMEOUT = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*IW-1:0] req_n = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 resp_valid;
  logic [1:0]           resp_id;
  logic [OW-1:0]        resp_result;
  logic                 resp_overflow;
  logic                 resp_timeout;
  logic                 busy;
  logic                 core_go;
  logic [IW-1:0]        core_n;
  logic [OW-1:0]        core_result;
  logic                 core_overflow;
  logic                 core_done;

  always #5 clk = ~clk;

  fib_arbiter #(
    .NUM_REQ(NUM_REQ), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_timeout(resp_timeout), .busy(busy),
    .core_go(core_go), .core_n(core_n), .core_result(core_result),
    .core_overflow(core_overflow), .core_done(core_done)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 0; b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  // Fib core stub: done stays high after completion until the next go.
  int           stub_cnt;
  logic [IW-1:0] stub_n;
  bit           stub_hang = 0;
  int           stub_lat_min = 2;
  int           stub_lat_max = 6;
  logic [63:0]  stub_f;
  assign stub_f = fib(int'(stub_n));

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_done <= 1'b0; core_result <= '0; core_overflow <= 1'b0;
      stub_cnt <= 0; stub_n <= '0;
    end else if (core_go) begin
      core_done <= 1'b0;
      stub_n    <= core_n;
      stub_cnt  <= stub_hang ? 0 : int'($urandom_range(stub_lat_max, stub_lat_min));
    end else if (stub_cnt == 1) begin
      core_done     <= 1'b1;
      core_result   <= stub_f[OW-1:0];
      core_overflow <= (stub_f[63:OW] != 0);
      stub_cnt      <= 0;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  // Logs written by the model when grants/responses occur.
  int          lg_id[$];
  int          lr_id[$];
  logic [63:0] lr_res[$];
  bit          lr_ovf[$];
  bit          lr_to[$];
  int          lr_wait[$];

  // Reference model and per-cycle compare, sampled on the falling edge.
  initial begin : compare
    int          cyc, m_gcyc, m_rcyc, m_g, m_ptr;
    bit          m_active, m_known, m_to, hit, prev_go, prev_rv;
    logic [IW-1:0] m_n;
    logic [63:0] m_f;
    logic [NUM_REQ-1:0] e_rdy;
    cyc = 0; m_active = 0; m_known = 0; m_ptr = 0; prev_go = 0; prev_rv = 0;
    m_gcyc = 0; m_rcyc = 0; m_g = 0; m_n = '0; m_to = 0; m_f = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_go", core_go, 0);
        chk("rst_core_n", core_n, 0);
        chk("rst_resp_fields", {resp_id, resp_result, resp_overflow, resp_timeout}, 0);
        m_active = 0; m_known = 0; m_ptr = 0; prev_go = 0; prev_rv = 0;
      end else begin
        e_rdy = (m_active && cyc == m_gcyc) ? NUM_REQ'(1) << m_g : '0;
        chk("req_ready", req_ready, e_rdy);
        chk("core_go", core_go, m_active && cyc == m_gcyc);
        chk("busy", busy, m_active);
        chk("resp_valid", resp_valid, m_active && m_known && cyc == m_rcyc);
        if (m_active) chk("core_n", core_n, m_n);
        if (m_active && m_known && cyc == m_rcyc) begin
          chk("resp_id", resp_id, m_g);
          chk("resp_timeout", resp_timeout, m_to);
          chk("resp_result", resp_result, m_to ? 0 : m_f[OW-1:0]);
          chk("resp_overflow", resp_overflow, m_to ? 0 : (m_f[63:OW] != 0));
          lr_id.push_back(m_g); lr_res.push_back(resp_result);
          lr_ovf.push_back(resp_overflow); lr_to.push_back(resp_timeout);
          lr_wait.push_back(m_rcyc - m_gcyc);
        end
        if (core_go) chk("go_double", prev_go, 0);
        if (resp_valid) chk("rv_double", prev_rv, 0);
        chk("ready_onehot0", $onehot0(req_ready), 1);
        prev_go = core_go; prev_rv = resp_valid;

        // Advance using the inputs the DUT samples on the coming edge.
        if (m_active && m_known && cyc == m_rcyc) begin
          m_active = 0;
          m_ptr = (m_g + 1) % NUM_REQ;
        end else if (m_active && !m_known && cyc > m_gcyc) begin
          if (core_done) begin
            m_known = 1; m_rcyc = cyc + 1; m_to = 0; m_f = fib(int'(m_n));
          end else if (cyc - m_gcyc == TIMEOUT) begin
            m_known = 1; m_rcyc = cyc + 1; m_to = 1;
          end
        end else if (!m_active && req_valid != 0) begin
          hit = 0;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (!hit && req_valid[(m_ptr + k) % NUM_REQ]) begin
              hit = 1; m_g = (m_ptr + k) % NUM_REQ;
            end
          end
          m_active = 1; m_known = 0; m_gcyc = cyc + 1;
          m_n = req_n[m_g*IW +: IW];
          lg_id.push_back(m_g);
        end
      end
    end
  end

  // Requester agents
  int          pend[NUM_REQ];
  logic [IW-1:0] dir_n[NUM_REQ];
  bit          rand_mode = 0;

  task automatic step();
    @(posedge clk); #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) req_valid[i] = 1'b0;
      else if (req_valid[i] && rand_mode && $urandom_range(31, 0) == 0) req_valid[i] = 1'b0;
      if (!req_valid[i] && pend[i] > 0 && (!rand_mode || $urandom_range(3, 0) == 0)) begin
        req_valid[i] = 1'b1;
        req_n[i*IW +: IW] = rand_mode ? IW'($urandom_range(63, 0)) : dir_n[i];
        pend[i]--;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 3) begin
      step(); n++;
      if (pend[0] + pend[1] + pend[2] + pend[3] == 0 && req_valid == 0 && !busy) quiet++;
      else quiet = 0;
      if (n > budget) begin
        n_chk++; n_err++;
        $display("FAIL wait_idle: timed out after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic request(input int id, input int n);
    dir_n[id] = IW'(n);
    pend[id]  = pend[id] + 1;
  endtask

  initial begin : main
    int b, t;
    int exp_id[5];
    int exp_res[5];
    exp_id  = '{0, 1, 2, 3, 0};
    exp_res = '{5, 8, 13, 21, 5};
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; dir_n[i] = '0; end

    chk("model_fib10", fib(10), 55);
    chk("model_fib63", fib(63), 64'd6557470319842);

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Single request, fixed core latency
    stub_lat_min = 4; stub_lat_max = 4;
    b = lr_id.size();
    request(0, 10);
    wait_idle(200);
    chk("t1_count", lr_id.size() - b, 1);
    if (lr_id.size() > b) begin
      chk("t1_id", lr_id[b], 0);
      chk("t1_res", lr_res[b], 55);
      chk("t1_ovf", lr_ovf[b], 0);
      chk("t1_wait", lr_wait[b], 6);
    end

    // All requesters from ptr=0
    #1 rst = 1'b0;
    step(); step();
    rst = 1'b1;
    stub_lat_min = 2; stub_lat_max = 7;
    b = lr_id.size();
    request(0, 5); request(1, 6); request(2, 7); request(3, 8);
    pend[0] = 2;
    wait_idle(400);
    chk("t2_count", lr_id.size() - b, 5);
    if (lr_id.size() >= b + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t2_id", lr_id[b+k], exp_id[k]);
        chk("t2_res", lr_res[b+k], exp_res[k]);
      end
    end

    // Wrap: ptr=2 with req1 and req3 pending
    request(1, 4);
    wait_idle(200);
    b = lg_id.size();
    request(1, 3); request(3, 2);
    wait_idle(300);
    chk("t3_count", lg_id.size() - b, 2);
    if (lg_id.size() >= b + 2) begin
      chk("t3_first", lg_id[b], 3);
      chk("t3_second", lg_id[b+1], 1);
    end

    // Overflow, then stale done must not complete the next run
    b = lr_id.size();
    request(2, 63);
    wait_idle(200);
    repeat (4) step();
    chk("t4_stale_done", core_done, 1);
    request(0, 3);
    wait_idle(200);
    chk("t4_count", lr_id.size() - b, 2);
    if (lr_id.size() >= b + 2) begin
      chk("t4_ovf", lr_ovf[b], 1);
      chk("t4_res", lr_res[b], 64'd3350226146);
      chk("t4_next_res", lr_res[b+1], 2);
      chk("t4_next_ovf", lr_ovf[b+1], 0);
    end

    // Watchdog
    b = lr_id.size();
    stub_hang = 1;
    request(3, 9);
    wait_idle(200);
    stub_hang = 0;
    request(2, 4);
    wait_idle(200);
    chk("t5_count", lr_id.size() - b, 2);
    if (lr_id.size() >= b + 2) begin
      chk("t5_to", lr_to[b], 1);
      chk("t5_res", lr_res[b], 0);
      chk("t5_wait", lr_wait[b], TIMEOUT + 1);
      chk("t5_next_to", lr_to[b+1], 0);
      chk("t5_next_res", lr_res[b+1], 3);
    end

    // Reset during WAIT
    stub_lat_min = 15; stub_lat_max = 15;
    b = lr_id.size();
    request(1, 12);
    t = 0;
    while (!busy && t < 50) begin step(); t++; end
    chk("t6_busy", busy, 1);
    repeat (5) step();
    rst = 1'b0;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_go", core_go, 0);
    chk("t6_async_ready", req_ready, 0);
    chk("t6_async_rv", resp_valid, 0);
    chk("t6_async_core_n", core_n, 0);
    repeat (3) step();
    rst = 1'b1;
    repeat (20) step();
    chk("t6_lost", lr_id.size() - b, 0);
    stub_lat_min = 2; stub_lat_max = 6;
    b = lg_id.size();
    request(2, 7); request(3, 1);
    wait_idle(300);
    chk("t6_count", lg_id.size() - b, 2);
    if (lg_id.size() >= b + 2) begin
      chk("t6_first", lg_id[b], 2);
      chk("t6_second", lg_id[b+1], 3);
    end

    // Randomized traffic with occasional hangs and late completions
    rand_mode = 1;
    stub_lat_min = 1; stub_lat_max = 24;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 25;
    t = 0;
    while (t < 20000 && (pend[0] + pend[1] + pend[2] + pend[3] != 0 || req_valid != 0 || busy)) begin
      stub_hang = ($urandom_range(15, 0) == 0);
      step(); t++;
    end
    chk("rand_drained", t < 20000, 1);
    stub_hang = 0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
